hazard_unit: RTL and testbench
==============================

// Module: hazard_unit
// PURPOSE
//  Pipeline hazard and forwarding responder for the 5-stage MIPS core. Consumes the
//  per-stage control bits produced by the controller (regwrite*/memtoreg*/branchD)
//  and register indices, and returns stall/flush/forward selects. Its flushE output
//  drives the controller's E-stage register clear. Tracks a multi-cycle divide in E.
// PARAMETERS
//  DIV_CYCLES  32  total stall cycles for one divide in E (legal 2..64)
// PORTS
//  clk        in   1   clock, rising edge
//  rst        in   1   synchronous, active-high reset
//  rsD,rtD    in   5   source regs in decode
//  rsE,rtE    in   5   source regs in execute
//  writeregE  in   5   dest reg in E; writeregM/writeregW likewise (5 each)
//  regwriteE/M/W in 1  regwrite per stage
//  memtoregE/M in  1   load in E / M
//  branchD    in   1   branch in decode
//  divE       in   1   divide op in E (from alucontrolE decode)
//  stallF,stallD,stallE out 1  hold PC / IF-ID / ID-EX regs
//  flushE,flushM out 1   clear ID-EX / EX-MEM regs (insert bubble)
//  forwardAD,forwardBD out 1  branch-compare forward from M
//  forwardAE,forwardBE out 2  ALU src select: 00 regfile, 01 W result, 10 M ALU out
//  divbusy    out  1   divide state machine in BUSY
//  stallcnt   out  32  count of cycles with stallF=1 (perf)
// BEHAVIOUR
//  Reset (rst=1 at edge): state<=IDLE, cnt<=0, stallcnt<=0. While rst=1 all
//  stall/flush/forward outputs forced 0, divbusy=0.
//  Reg 0 never matches (any compare with index 0 is false).
//  forwardAE = 10 if regwriteM & writeregM==rsE; else 01 if regwriteW &
//   writeregW==rsE; else 00. forwardBE same with rtE. M wins over W.
//  forwardAD = regwriteM & writeregM==rsD; forwardBD with rtD.
//  lwstall = memtoregE & regwriteE & writeregE in {rsD,rtD}.
//  brstall = branchD & ((regwriteE & writeregE in {rsD,rtD}) |
//            (memtoregM & writeregM in {rsD,rtD})).
//  Divide FSM (IDLE/BUSY, cnt width clog2(DIV_CYCLES)):
//   IDLE & divE: divstall=1; next BUSY, cnt<=DIV_CYCLES-1.
//   BUSY & cnt!=0: divstall=1, cnt<=cnt-1.
//   BUSY & cnt==0: divstall=0 (result ready), next IDLE.
//   => exactly DIV_CYCLES stalled cycles per divide; back-to-back divides each
//      restart from IDLE on the cycle the next one occupies E.
//  Outputs (combinational from inputs + state, same cycle):
//   stallF = stallD = lwstall | brstall | divstall.
//   stallE = divstall; flushM = divstall.
//   flushE = (lwstall | brstall) & ~divstall  (E held, not cleared, during divide).
//  divbusy = (state==BUSY). stallcnt += 1 each cycle stallF=1; wraps at 2^32-1 -> 0.
//  Reset mid-divide: FSM to IDLE immediately; no residual stall next cycle unless
//  divE still asserted.
// TESTING
//  add $3 in M, sub rsE=3 in E, regwriteM=1 -> forwardAE=10; also W writes $3 ->
//   still 10; M writes $0 only -> 00.
//  lw $5 in E (memtoregE=regwriteE=1), rtD=5 -> stallF=stallD=flushE=1, stallE=0.
//  beq rsD=7 with regwriteE writeregE=7 -> brstall 1 cycle; next cycle writeregM=7
//   non-load -> no stall, forwardAD=1.
//  DIV_CYCLES=4, divE held -> stallE=flushM=1 for exactly 4 cycles, 5th cycle 0,
//   divbusy high cycles 2-5; stallcnt increments by 4.
//  divE plus lwstall in same cycle -> flushE=0, stallE=1.
//  rst pulse at BUSY cnt=2 -> next cycle divbusy=0, all outputs 0 with rst high, stallcnt=0.

Source files
------------

// File: rtl/hazard_unit.sv
// Hazard and forwarding unit for the 5-stage MIPS pipeline.
// Resolves load-use, branch and multi-cycle divide stalls plus E/D-stage forwarding.
module hazard_unit #(
    parameter int DIV_CYCLES = 32
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [4:0]  rsD,
    input  logic [4:0]  rtD,
    input  logic [4:0]  rsE,
    input  logic [4:0]  rtE,
    input  logic [4:0]  writeregE,
    input  logic [4:0]  writeregM,
    input  logic [4:0]  writeregW,
    input  logic        regwriteE,
    input  logic        regwriteM,
    input  logic        regwriteW,
    input  logic        memtoregE,
    input  logic        memtoregM,
    input  logic        branchD,
    input  logic        divE,
    output logic        stallF,
    output logic        stallD,
    output logic        stallE,
    output logic        flushE,
    output logic        flushM,
    output logic        forwardAD,
    output logic        forwardBD,
    output logic [1:0]  forwardAE,
    output logic [1:0]  forwardBE,
    output logic        divbusy,
    output logic [31:0] stallcnt
);

    localparam int CW = (DIV_CYCLES > 1) ? $clog2(DIV_CYCLES) : 1;

    typedef enum logic {
        IDLE,
        BUSY
    } state_e;

    state_e         state_q, state_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [31:0]    stallcnt_q, stallcnt_d;

    logic           lwstall;
    logic           brstall;
    logic           divstall;

    // Register $0 is hardwired, so it never creates a dependency.
    function automatic logic hit(input logic [4:0] a, input logic [4:0] b);
        return (a != 5'd0) && (a == b);
    endfunction

    function automatic logic [1:0] fwd_sel(
        input logic [4:0] src,
        input logic       wm,
        input logic [4:0] rm,
        input logic       ww,
        input logic [4:0] rw
    );
        if (wm && hit(rm, src)) begin
            return 2'b10;
        end else if (ww && hit(rw, src)) begin
            return 2'b01;
        end
        return 2'b00;
    endfunction

    always_comb begin
        lwstall = memtoregE & regwriteE &
                  (hit(writeregE, rsD) | hit(writeregE, rtD));
        brstall = branchD &
                  ((regwriteE & (hit(writeregE, rsD) | hit(writeregE, rtD))) |
                   (memtoregM & (hit(writeregM, rsD) | hit(writeregM, rtD))));
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        divstall = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (divE) begin
                    divstall = 1'b1;
                    state_d  = BUSY;
                    cnt_d    = CW'(DIV_CYCLES - 1);
                end
            end
            BUSY: begin
                if (cnt_q != '0) begin
                    divstall = 1'b1;
                    cnt_d    = cnt_q - CW'(1);
                end else begin
                    state_d  = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Every status output is held low while reset is asserted.
    always_comb begin
        stallF    = ~rst & (lwstall | brstall | divstall);
        stallD    = stallF;
        stallE    = ~rst & divstall;
        flushM    = ~rst & divstall;
        flushE    = ~rst & (lwstall | brstall) & ~divstall;
        forwardAD = ~rst & regwriteM & hit(writeregM, rsD);
        forwardBD = ~rst & regwriteM & hit(writeregM, rtD);
        forwardAE = rst ? 2'b00 :
                    fwd_sel(rsE, regwriteM, writeregM, regwriteW, writeregW);
        forwardBE = rst ? 2'b00 :
                    fwd_sel(rtE, regwriteM, writeregM, regwriteW, writeregW);
        divbusy   = ~rst & (state_q == BUSY);
        stallcnt  = stallcnt_q;
    end

    assign stallcnt_d = stallcnt_q + 32'(stallF);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            stallcnt_q <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            stallcnt_q <= stallcnt_d;
        end
    end

endmodule

// File: tb/tb_hazard_unit.sv
// Directed self-checking bench for hazard_unit with a 4-cycle divide.
// Each task drives one scenario and checks outputs a step after driving.
module tb_hazard_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic [4:0]  rsD, rtD, rsE, rtE;
    logic [4:0]  writeregE, writeregM, writeregW;
    logic        regwriteE, regwriteM, regwriteW;
    logic        memtoregE, memtoregM, branchD, divE;
    logic        stallF, stallD, stallE, flushE, flushM;
    logic        forwardAD, forwardBD, divbusy;
    logic [1:0]  forwardAE, forwardBE;
    logic [31:0] stallcnt;

    int pass_cnt = 0;
    int total    = 0;
    int exp_cnt  = 0;

    hazard_unit #(.DIV_CYCLES(4)) dut (
        .clk(clk), .rst(rst),
        .rsD(rsD), .rtD(rtD), .rsE(rsE), .rtE(rtE),
        .writeregE(writeregE), .writeregM(writeregM), .writeregW(writeregW),
        .regwriteE(regwriteE), .regwriteM(regwriteM), .regwriteW(regwriteW),
        .memtoregE(memtoregE), .memtoregM(memtoregM),
        .branchD(branchD), .divE(divE),
        .stallF(stallF), .stallD(stallD), .stallE(stallE),
        .flushE(flushE), .flushM(flushM),
        .forwardAD(forwardAD), .forwardBD(forwardBD),
        .forwardAE(forwardAE), .forwardBE(forwardBE),
        .divbusy(divbusy), .stallcnt(stallcnt)
    );

    always #5 clk = ~clk;

    task automatic clear_inputs();
        rsD = 0; rtD = 0; rsE = 0; rtE = 0;
        writeregE = 0; writeregM = 0; writeregW = 0;
        regwriteE = 0; regwriteM = 0; regwriteW = 0;
        memtoregE = 0; memtoregM = 0; branchD = 0; divE = 0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        clear_inputs();
        tick();
        tick();
        regwriteM = 1; writeregM = 3; rsE = 3; rtD = 3;
        divE = 1; #1;
        total++; if (forwardAE !== 2'b00) $display("FAIL rst_fwdAE got=%b exp=00", forwardAE); else pass_cnt++;
        total++; if (forwardBD !== 1'b0) $display("FAIL rst_fwdBD got=%b exp=0", forwardBD); else pass_cnt++;
        total++; if (stallF !== 1'b0) $display("FAIL rst_stallF got=%b exp=0", stallF); else pass_cnt++;
        total++; if (stallE !== 1'b0) $display("FAIL rst_stallE got=%b exp=0", stallE); else pass_cnt++;
        total++; if (divbusy !== 1'b0) $display("FAIL rst_divbusy got=%b exp=0", divbusy); else pass_cnt++;
        total++; if (stallcnt !== 32'd0) $display("FAIL rst_stallcnt got=%0d exp=0", stallcnt); else pass_cnt++;
        clear_inputs();
        rst = 1'b0;
        tick();
    endtask

    task automatic test_forward_e();
        clear_inputs();
        regwriteM = 1; writeregM = 3; rsE = 3; rtE = 4; #1;
        total++; if (forwardAE !== 2'b10) $display("FAIL fwdAE_M got=%b exp=10", forwardAE); else pass_cnt++;
        total++; if (forwardBE !== 2'b00) $display("FAIL fwdBE_none got=%b exp=00", forwardBE); else pass_cnt++;
        regwriteW = 1; writeregW = 3; #1;
        total++; if (forwardAE !== 2'b10) $display("FAIL fwdAE_MW got=%b exp=10", forwardAE); else pass_cnt++;
        writeregW = 4; #1;
        total++; if (forwardBE !== 2'b01) $display("FAIL fwdBE_W got=%b exp=01", forwardBE); else pass_cnt++;
        regwriteM = 0; writeregW = 3; #1;
        total++; if (forwardAE !== 2'b01) $display("FAIL fwdAE_W got=%b exp=01", forwardAE); else pass_cnt++;
        regwriteM = 1; writeregM = 0; regwriteW = 0; writeregW = 0; rsE = 0; #1;
        total++; if (forwardAE !== 2'b00) $display("FAIL fwdAE_r0 got=%b exp=00", forwardAE); else pass_cnt++;
        clear_inputs();
    endtask

    task automatic test_lwstall();
        clear_inputs();
        memtoregE = 1; regwriteE = 1; writeregE = 5; rtD = 5; #1;
        total++; if (stallF !== 1'b1) $display("FAIL lw_stallF got=%b exp=1", stallF); else pass_cnt++;
        total++; if (stallD !== 1'b1) $display("FAIL lw_stallD got=%b exp=1", stallD); else pass_cnt++;
        total++; if (flushE !== 1'b1) $display("FAIL lw_flushE got=%b exp=1", flushE); else pass_cnt++;
        total++; if (stallE !== 1'b0) $display("FAIL lw_stallE got=%b exp=0", stallE); else pass_cnt++;
        total++; if (flushM !== 1'b0) $display("FAIL lw_flushM got=%b exp=0", flushM); else pass_cnt++;
        tick();
        exp_cnt++;
        total++; if (stallcnt !== 32'(exp_cnt)) $display("FAIL lw_cnt got=%0d exp=%0d", stallcnt, exp_cnt); else pass_cnt++;
        writeregE = 0; rtD = 0; #1;
        total++; if (stallF !== 1'b0) $display("FAIL lw_r0 got=%b exp=0", stallF); else pass_cnt++;
        clear_inputs();
    endtask

    task automatic test_branch();
        clear_inputs();
        branchD = 1; rsD = 7; regwriteE = 1; writeregE = 7; #1;
        total++; if (stallF !== 1'b1) $display("FAIL br_stallF got=%b exp=1", stallF); else pass_cnt++;
        total++; if (flushE !== 1'b1) $display("FAIL br_flushE got=%b exp=1", flushE); else pass_cnt++;
        tick();
        exp_cnt++;
        regwriteE = 0; writeregE = 0;
        regwriteM = 1; writeregM = 7; #1;
        total++; if (stallF !== 1'b0) $display("FAIL br_nostall got=%b exp=0", stallF); else pass_cnt++;
        total++; if (forwardAD !== 1'b1) $display("FAIL br_fwdAD got=%b exp=1", forwardAD); else pass_cnt++;
        total++; if (forwardBD !== 1'b0) $display("FAIL br_fwdBD got=%b exp=0", forwardBD); else pass_cnt++;
        memtoregM = 1; #1;
        total++; if (stallD !== 1'b1) $display("FAIL br_ldM got=%b exp=1", stallD); else pass_cnt++;
        clear_inputs();
        tick();
        total++; if (stallcnt !== 32'(exp_cnt)) $display("FAIL br_cnt got=%0d exp=%0d", stallcnt, exp_cnt); else pass_cnt++;
    endtask

    task automatic test_divide();
        clear_inputs();
        divE = 1;
        for (int i = 1; i <= 5; i++) begin
            #1;
            total++; if (stallE !== (i <= 4)) $display("FAIL div_stallE c%0d got=%b exp=%b", i, stallE, (i <= 4)); else pass_cnt++;
            total++; if (flushM !== (i <= 4)) $display("FAIL div_flushM c%0d got=%b exp=%b", i, flushM, (i <= 4)); else pass_cnt++;
            total++; if (divbusy !== (i >= 2)) $display("FAIL div_busy c%0d got=%b exp=%b", i, divbusy, (i >= 2)); else pass_cnt++;
            total++; if (flushE !== 1'b0) $display("FAIL div_flushE c%0d got=%b exp=0", i, flushE); else pass_cnt++;
            if (i <= 4) exp_cnt++;
            if (i == 5) divE = 0;
            tick();
        end
        total++; if (divbusy !== 1'b0) $display("FAIL div_idle got=%b exp=0", divbusy); else pass_cnt++;
        total++; if (stallcnt !== 32'(exp_cnt)) $display("FAIL div_cnt got=%0d exp=%0d", stallcnt, exp_cnt); else pass_cnt++;
    endtask

    task automatic test_div_lw_and_reset();
        clear_inputs();
        divE = 1; memtoregE = 1; regwriteE = 1; writeregE = 9; rsD = 9; #1;
        total++; if (flushE !== 1'b0) $display("FAIL dl_flushE got=%b exp=0", flushE); else pass_cnt++;
        total++; if (stallE !== 1'b1) $display("FAIL dl_stallE got=%b exp=1", stallE); else pass_cnt++;
        total++; if (stallF !== 1'b1) $display("FAIL dl_stallF got=%b exp=1", stallF); else pass_cnt++;
        tick();
        tick();
        total++; if (divbusy !== 1'b1) $display("FAIL dl_busy got=%b exp=1", divbusy); else pass_cnt++;
        total++; if (flushE !== 1'b0) $display("FAIL dl_busy_flushE got=%b exp=0", flushE); else pass_cnt++;
        rst = 1; #1;
        total++; if (divbusy !== 1'b0) $display("FAIL mr_busy got=%b exp=0", divbusy); else pass_cnt++;
        total++; if (stallF !== 1'b0) $display("FAIL mr_stallF got=%b exp=0", stallF); else pass_cnt++;
        tick();
        exp_cnt = 0;
        total++; if (stallcnt !== 32'(exp_cnt)) $display("FAIL mr_cnt got=%0d exp=0", stallcnt); else pass_cnt++;
        total++; if (stallE !== 1'b0) $display("FAIL mr_stallE got=%b exp=0", stallE); else pass_cnt++;
        rst = 0;
        clear_inputs(); #1;
        total++; if (stallE !== 1'b0) $display("FAIL mr_resid got=%b exp=0", stallE); else pass_cnt++;
        total++; if (divbusy !== 1'b0) $display("FAIL mr_idle got=%b exp=0", divbusy); else pass_cnt++;
        divE = 1; #1;
        total++; if (stallE !== 1'b1) $display("FAIL mr_newdiv got=%b exp=1", stallE); else pass_cnt++;
        clear_inputs();
    endtask

    initial begin
        test_reset();
        test_forward_e();
        test_lwstall();
        test_branch();
        test_divide();
        test_div_lw_and_reset();
        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end

endmodule
